serial_initiator_tx: RTL and testbench

Initiator-side serializer that drives the shared serial bus the address decoder listens to. Accepts a parallel address and write-data word, requests the bus from the arbiter, then shifts the address LSB-first in address mode and the data LSB-first in data mode. Inserts the idle gaps the decoder needs to latch its target select before data and to release it afterwards. Sits between an initiator's parallel request interface and the bus arbiter/mux.

---
 rtl/serial_initiator_tx_pkg.sv | 19 +
 rtl/serial_initiator_tx.sv | 118 +++++++++++
 tb/tb_serial_initiator_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_initiator_tx_pkg.sv
// Shared serial-bus definitions used by the initiator serializer and the address decoder.
package serial_initiator_tx_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 8;

  localparam logic BUS_MODE_ADDR = 1'b0;
  localparam logic BUS_MODE_DATA = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    GAP_A,
    DATA,
    GAP_D
  } tx_state_t;

endpackage

// File: rtl/serial_initiator_tx.sv
// Initiator-side serializer: requests the bus, shifts address then data LSB-first,
// and inserts idle gaps so the decoder can latch and later release its target select.
module serial_initiator_tx
  import serial_initiator_tx_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  grant,
  output logic                  busy,
  output logic                  done,
  output logic                  bus_req,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int GW   = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  tx_state_t             state_q;
  logic [ADDR_WIDTH-1:0] addr_sh_q;
  logic [DATA_WIDTH-1:0] data_sh_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [GW-1:0]         gap_cnt_q;

  // Frame sequencer: a grant-less cycle in a shift phase simply holds position,
  // while the gaps count wall-clock cycles because the decoder's timing is fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_sh_q <= addr;
            data_sh_q <= wdata;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (grant) state_q <= ADDR;
        end
        ADDR: begin
          if (grant) begin
            addr_sh_q <= addr_sh_q >> 1;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_q <= '0;
              gap_cnt_q <= '0;
              state_q   <= GAP_A;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        GAP_A: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        DATA: begin
          if (grant) begin
            data_sh_q <= data_sh_q >> 1;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              gap_cnt_q <= '0;
              state_q   <= GAP_D;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        GAP_D: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; only valid follows grant directly so a
  // lost grant never puts a bit on the bus.
  assign busy               = (state_q != IDLE);
  assign bus_req            = (state_q != IDLE);
  assign bus_mode           = (state_q == GAP_A || state_q == DATA || state_q == GAP_D)
                              ? BUS_MODE_DATA : BUS_MODE_ADDR;
  assign bus_data_out_valid = (state_q == ADDR || state_q == DATA) && grant;
  assign bus_data_out       = (state_q == ADDR) ? addr_sh_q[0] :
                              (state_q == DATA) ? data_sh_q[0] : 1'b0;
  assign done               = (state_q == GAP_D) && (gap_cnt_q == GAP_LAST);

endmodule

// File: tb/tb_serial_initiator_tx.sv
// Scoreboard bench for serial_initiator_tx: drivers push expected bus events,
// a negedge monitor pops and compares whenever a bit or done appears.
module tb_serial_initiator_tx;
  import serial_initiator_tx_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int GC  = 1;
  localparam int LAT = AW + DW + 2*GC + 1;   // 27 cycles start -> done

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          grant = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic busy, done, bus_req, bus_data_out, bus_data_out_valid, bus_mode;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit is_done;
    bit mode;
    bit b;
    int at;
  } ev_t;
  ev_t exp_q[$];

  serial_initiator_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
    .grant(grant), .busy(busy), .done(done), .bus_req(bus_req),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .bus_mode(bus_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid bit and every done pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (bus_data_out_valid || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (bus_data_out_valid) begin
          chk("sb_kind_bit", 0, int'(e.is_done));
          chk("sb_mode", int'(bus_mode), int'(e.mode));
          chk("sb_bit", int'(bus_data_out), int'(e.b));
        end else begin
          chk("sb_kind_done", 1, int'(e.is_done));
          chk("sb_done_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic push_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int nd, input bit with_done, input int at);
    for (int i = 0; i < AW; i++) exp_q.push_back('{1'b0, BUS_MODE_ADDR, a[i], 0});
    for (int i = 0; i < nd; i++) exp_q.push_back('{1'b0, BUS_MODE_DATA, d[i], 0});
    if (with_done) exp_q.push_back('{1'b1, BUS_MODE_DATA, 1'b0, at});
  endtask

  // Drives one frame from the current cycle. pre: grant-low cycles in REQ;
  // stall_at/slen: grant-low window after address bit stall_at-1; extra_k: cycle
  // offset of an extra start that must be ignored (0 = none).
  task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int pre, input int stall_at, input int slen,
                            input int extra_k);
    int c0, t;
    c0 = cyc;
    t  = LAT + pre + slen;
    push_frame(a, d, DW, 1'b1, c0 + t);
    start = 1'b1; addr = a; wdata = d; grant = 1'b1;
    for (int k = 1; k <= t + 1; k++) begin
      @(posedge clk); #1;
      start = (k == extra_k);
      if (start) begin addr = 16'h8000; wdata = 8'h3C; end
      grant = !((k <= pre) ||
                (slen > 0 && k >= 2 + pre + stall_at && k < 2 + pre + stall_at + slen));
      @(negedge clk);
      if (k <= t) begin
        chk("busy_in_frame", int'(busy), 1);
        chk("req_in_frame", int'(bus_req), 1);
      end else begin
        chk("busy_after_done", int'(busy), 0);
        chk("req_after_done", int'(bus_req), 0);
      end
      if (!grant) chk("valid_without_grant", int'(bus_data_out_valid), 0);
      if (k == pre + 2 + AW + slen) begin
        chk("gap_a_valid", int'(bus_data_out_valid), 0);
        chk("gap_a_mode", int'(bus_mode), 1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_req"}, int'(bus_req), 0);
    chk({tag, "_data"}, int'(bus_data_out), 0);
    chk({tag, "_valid"}, int'(bus_data_out_valid), 0);
    chk({tag, "_mode"}, int'(bus_mode), 0);
  endtask

  initial begin
    int c0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame: address bits 1,1,0,0,0,1,0,0,1,0,0,0,0,0,1,0; data 1,0,1,0,0,1,0,1.
    send_frame(16'h4123, 8'hA5, 0, 0, 0, 0);
    // Grant withheld 5 cycles in REQ.
    send_frame(16'h4123, 8'hA5, 5, 0, 0, 0);
    // Grant drops for 3 cycles after address bit 7.
    send_frame(16'h4123, 8'hA5, 0, 8, 3, 0);
    // Back-to-back frames, each start on the cycle after done.
    send_frame(16'h0012, 8'h5A, 0, 0, 0, 0);
    send_frame(16'h8ABC, 8'hC3, 0, 0, 0, 0);
    // Start while busy at cycle 10 must be ignored.
    send_frame(16'h1234, 8'h0F, 0, 0, 0, 10);
    repeat (5) begin
      @(negedge clk);
      chk("idle_after_ignored_start", int'(busy), 0);
    end

    // Reset mid-data at data bit 4: bits 0..3 only, no done.
    @(posedge clk); #1;
    c0 = cyc;
    push_frame(16'hBEEF, 8'hF0, 4, 1'b0, 0);
    start = 1'b1; addr = 16'hBEEF; wdata = 8'hF0; grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 2 + AW + GC + 4) begin
      @(posedge clk); #1;
    end
    chk("reset_hit_valid_before", int'(bus_data_out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    chk("mid_reset_queue", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    send_frame(16'h4123, 8'hA5, 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
